triangle_assembler: RTL and testbench
=====================================

TRIANGLE_ASSEMBLER -- requirements
Module: triangle_assembler

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 12, signed pixel coordinate width.
REQ-002 SHALL have parameter DEPTH_BITS, default 12, unsigned Q0.12 depth width.
REQ-003 SHALL have parameter WIDTH, default 320, screen width in pixels.
REQ-004 SHALL have parameter HEIGHT, default 320, screen height in pixels.
REQ-005 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-006 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_vertex_pixel[2]  input  DATAWIDTH each, signed  screen x (index 0) and y (index 1).
REQ-008 SHALL have port i_vertex_z  input  DEPTH_BITS  vertex depth.
REQ-009 SHALL have port i_vertex_dv  input  1  one-cycle vertex strobe.
REQ-010 SHALL have port i_vertex_invalid  input  1  vertex failed clipping/divide, sampled with i_vertex_dv.
REQ-011 SHALL have port o_ready  output  1  block accepts a vertex this cycle.
REQ-012 SHALL have ports o_tri_x[3], o_tri_y[3]  output  DATAWIDTH each, signed  triangle vertices.
REQ-013 SHALL have port o_tri_z[3]  output  DEPTH_BITS each  vertex depths.
REQ-014 SHALL have ports o_bb_min_x, o_bb_max_x, o_bb_min_y, o_bb_max_y  output  DATAWIDTH each  clamped bounding box.
REQ-015 SHALL have port o_area  output  2*DATAWIDTH+2, signed  twice the signed triangle area.
REQ-016 SHALL have port o_tri_dv  output  1  triangle valid, held until accepted.
REQ-017 SHALL have port i_tri_ready  input  1  downstream accepts; transfer when o_tri_dv and i_tri_ready both high.
REQ-018 SHALL have port o_culled_count  output  16  saturating count of discarded triangles.
REQ-019 SHALL have port o_overrun  output  1  sticky: vertex strobe arrived while o_ready low.

Function
REQ-020 SHALL implement states COLLECT, AREA, BBOX, EMIT; o_ready high only in COLLECT.
REQ-021 SHALL in COLLECT store each accepted vertex in slot idx (2-bit counter 0..2), OR i_vertex_invalid into a triangle-invalid flag, and go to AREA on accepting slot 2.
REQ-022 SHALL drop any i_vertex_dv while o_ready low and set o_overrun until reset.
REQ-023 SHALL in AREA register area = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0), sign-extended to full o_area width with no overflow.
REQ-024 SHALL in BBOX compute min/max of x and y over the three vertices, clamped to [0, WIDTH-1] and [0, HEIGHT-1].
REQ-025 SHALL discard the triangle in BBOX when: invalid flag set, area == 0, unclamped max_x < 0, unclamped min_x > WIDTH-1, unclamped max_y < 0, or unclamped min_y > HEIGHT-1. Culling by area sign is governed by REQ-035/036.
REQ-026 SHALL on discard increment o_culled_count (saturate at 65535), clear idx and the invalid flag, and return to COLLECT.
REQ-027 SHALL otherwise enter EMIT with o_tri_dv high and all triangle outputs stable.
REQ-028 SHALL keep o_tri_dv high in EMIT until i_tri_ready, then drop o_tri_dv next cycle and return to COLLECT with idx = 0.
REQ-029 SHALL give latency: third vertex accepted at edge T -> o_tri_dv high after edge T+3, when not culled and not stalled.
REQ-030 SHALL hold o_ready low from AREA through EMIT, so the next vertex is accepted no earlier than the cycle after the handshake.

Reset
REQ-031 SHALL on rstn low asynchronously force state COLLECT, idx 0, invalid flag 0, o_tri_dv 0, o_overrun 0, o_culled_count 0, and all data outputs 0.
REQ-032 SHALL discard any partial triangle or pending EMIT when reset asserts mid-operation; no o_tri_dv after release until three new vertices arrive.
REQ-033 SHALL assert o_ready in the first cycle after reset release.

Configuration
REQ-034 SHALL use the macro BACKFACE_CULL_EN.
REQ-035 SHALL when BACKFACE_CULL_EN is defined also discard triangles with area < 0 (back-facing).
REQ-036 SHALL when BACKFACE_CULL_EN is undefined emit area < 0 triangles with vertex slots 1 and 2 swapped and o_area negated, so o_area > 0 for every emitted triangle.

Verification
REQ-037 SHALL test: vertices (10,10),(50,10),(10,50), z 100/200/300, i_tri_ready=1 -> o_tri_dv 3 cycles after third vertex, o_area=1600, bbox x 10..50, y 10..50.
REQ-038 SHALL test: vertices (10,10),(10,50),(50,10) -> with BACKFACE_CULL_EN o_culled_count=1 and no o_tri_dv; without it, emit slots (10,10),(50,10),(10,50) and o_area=1600.
REQ-039 SHALL test: second vertex strobed with i_vertex_invalid=1 -> triangle discarded, o_culled_count=1, next three valid vertices emitted normally.
REQ-040 SHALL test: vertices (-20,-20),(400,-20),(-20,400) -> bbox clamped to 0..319 both axes, o_area=176400.
REQ-041 SHALL test: i_tri_ready low for 5 cycles in EMIT -> o_tri_dv and outputs stable, o_ready low, and a vertex strobe in that window sets o_overrun.
REQ-042 SHALL test: rstn pulsed low after two vertices -> outputs zeroed, and three further vertices form exactly one triangle.

Source files
------------

// File: rtl/triangle_assembler.sv
// triangle_assembler: gathers three vertices into a triangle, computes area and clamped bbox, culls or emits (option macro BACKFACE_CULL_EN)
module triangle_assembler #(
  parameter int DATAWIDTH  = 12,
  parameter int DEPTH_BITS = 12,
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 320
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic signed [DATAWIDTH-1:0]    i_vertex_pixel [2],
  input  logic        [DEPTH_BITS-1:0]   i_vertex_z,
  input  logic                           i_vertex_dv,
  input  logic                           i_vertex_invalid,
  output logic                           o_ready,
  output logic signed [DATAWIDTH-1:0]    o_tri_x [3],
  output logic signed [DATAWIDTH-1:0]    o_tri_y [3],
  output logic        [DEPTH_BITS-1:0]   o_tri_z [3],
  output logic signed [DATAWIDTH-1:0]    o_bb_min_x,
  output logic signed [DATAWIDTH-1:0]    o_bb_max_x,
  output logic signed [DATAWIDTH-1:0]    o_bb_min_y,
  output logic signed [DATAWIDTH-1:0]    o_bb_max_y,
  output logic signed [2*DATAWIDTH+1:0]  o_area,
  output logic                           o_tri_dv,
  input  logic                           i_tri_ready,
  output logic        [15:0]             o_culled_count,
  output logic                           o_overrun
);
  typedef enum logic [1:0] {COLLECT, AREA, BBOX, EMIT} state_t;
  localparam int AW = 2*DATAWIDTH+2;
  localparam logic signed [DATAWIDTH-1:0] X_HI = DATAWIDTH'(WIDTH-1);
  localparam logic signed [DATAWIDTH-1:0] Y_HI = DATAWIDTH'(HEIGHT-1);
`ifdef BACKFACE_CULL_EN
  localparam bit BF = 1'b1;
`else
  localparam bit BF = 1'b0;
`endif
  state_t state;
  logic [1:0] idx;
  logic inv, bb_done, cull_r, cull_c, sw;
  logic signed [DATAWIDTH-1:0] vx [3];
  logic signed [DATAWIDTH-1:0] vy [3];
  logic [DEPTH_BITS-1:0] vz [3];
  logic signed [AW-1:0] area_r, area_c, dx1, dy1, dx2, dy2;
  logic signed [DATAWIDTH-1:0] mn_x, mx_x, mn_y, mx_y;

  function automatic logic signed [DATAWIDTH-1:0] clamp(input logic signed [DATAWIDTH-1:0] v, input logic signed [DATAWIDTH-1:0] hi);
    return v < 0 ? '0 : (v > hi ? hi : v);
  endfunction

  assign o_ready = state == COLLECT;
  assign sw = area_r < 0;

  // area at full width plus unclamped extents and cull decision from the stored slots
  always_comb begin
    dx1 = AW'(vx[1]) - AW'(vx[0]);
    dy1 = AW'(vy[1]) - AW'(vy[0]);
    dx2 = AW'(vx[2]) - AW'(vx[0]);
    dy2 = AW'(vy[2]) - AW'(vy[0]);
    area_c = dx1 * dy2 - dx2 * dy1;
    mn_x = vx[0];
    mx_x = vx[0];
    mn_y = vy[0];
    mx_y = vy[0];
    for (int i = 1; i < 3; i++) begin
      mn_x = vx[i] < mn_x ? vx[i] : mn_x;
      mx_x = vx[i] > mx_x ? vx[i] : mx_x;
      mn_y = vy[i] < mn_y ? vy[i] : mn_y;
      mx_y = vy[i] > mx_y ? vy[i] : mx_y;
    end
    cull_c = inv || area_r == '0 || mx_x < 0 || mn_x > X_HI || mx_y < 0 || mn_y > Y_HI || (BF && area_r < 0);
  end

  // collect -> area -> bbox (extents, then decide) -> emit/handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= COLLECT;
      idx            <= '0;
      inv            <= 1'b0;
      bb_done        <= 1'b0;
      cull_r         <= 1'b0;
      vx             <= '{default: '0};
      vy             <= '{default: '0};
      vz             <= '{default: '0};
      area_r         <= '0;
      o_tri_x        <= '{default: '0};
      o_tri_y        <= '{default: '0};
      o_tri_z        <= '{default: '0};
      o_bb_min_x     <= '0;
      o_bb_max_x     <= '0;
      o_bb_min_y     <= '0;
      o_bb_max_y     <= '0;
      o_area         <= '0;
      o_tri_dv       <= 1'b0;
      o_culled_count <= '0;
      o_overrun      <= 1'b0;
    end else begin
      if (i_vertex_dv && state != COLLECT) o_overrun <= 1'b1;
      case (state)
        COLLECT: if (i_vertex_dv) begin
          vx[idx] <= i_vertex_pixel[0];
          vy[idx] <= i_vertex_pixel[1];
          vz[idx] <= i_vertex_z;
          inv     <= inv | i_vertex_invalid;
          idx     <= idx == 2'd2 ? 2'd0 : idx + 2'd1;
          if (idx == 2'd2) state <= AREA;
        end
        AREA: begin
          area_r <= area_c;
          state  <= BBOX;
        end
        BBOX: if (!bb_done) begin
          bb_done    <= 1'b1;
          cull_r     <= cull_c;
          o_bb_min_x <= clamp(mn_x, X_HI);
          o_bb_max_x <= clamp(mx_x, X_HI);
          o_bb_min_y <= clamp(mn_y, Y_HI);
          o_bb_max_y <= clamp(mx_y, Y_HI);
        end else begin
          bb_done <= 1'b0;
          inv     <= 1'b0;
          idx     <= '0;
          if (cull_r) begin
            state <= COLLECT;
            if (o_culled_count != '1) o_culled_count <= o_culled_count + 16'd1;
          end else begin
            state      <= EMIT;
            o_tri_dv   <= 1'b1;
            o_tri_x[0] <= vx[0];
            o_tri_y[0] <= vy[0];
            o_tri_z[0] <= vz[0];
            o_tri_x[1] <= sw ? vx[2] : vx[1];
            o_tri_y[1] <= sw ? vy[2] : vy[1];
            o_tri_z[1] <= sw ? vz[2] : vz[1];
            o_tri_x[2] <= sw ? vx[1] : vx[2];
            o_tri_y[2] <= sw ? vy[1] : vy[2];
            o_tri_z[2] <= sw ? vz[1] : vz[2];
            o_area     <= sw ? -area_r : area_r;
          end
        end
        EMIT: if (i_tri_ready) begin
          o_tri_dv <= 1'b0;
          state    <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_triangle_assembler.sv
// tb_triangle_assembler: directed and random triangles checked against an arithmetic reference model
module tb_triangle_assembler;
  localparam int DW = 12;
  localparam int ZB = 12;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic signed [DW-1:0] vp [2];
  logic [ZB-1:0] vz = '0;
  logic vdv = 1'b0;
  logic vinv = 1'b0;
  logic tri_rdy = 1'b1;
  logic ready, tri_dv, overrun;
  logic signed [DW-1:0] tri_x [3];
  logic signed [DW-1:0] tri_y [3];
  logic [ZB-1:0] tri_z [3];
  logic signed [DW-1:0] bminx, bmaxx, bminy, bmaxy;
  logic signed [2*DW+1:0] area;
  logic [15:0] culled;
  int vectors = 0;
  int miscompares = 0;
  int exp_cull = 0;
  int tx [3];
  int ty [3];
  int tz [3];
  bit tinv [3];

  always #5 clk = ~clk;

  triangle_assembler dut (
    .clk(clk), .rstn(rstn), .i_vertex_pixel(vp), .i_vertex_z(vz), .i_vertex_dv(vdv),
    .i_vertex_invalid(vinv), .o_ready(ready), .o_tri_x(tri_x), .o_tri_y(tri_y), .o_tri_z(tri_z),
    .o_bb_min_x(bminx), .o_bb_max_x(bmaxx), .o_bb_min_y(bminy), .o_bb_max_y(bmaxy),
    .o_area(area), .o_tri_dv(tri_dv), .i_tri_ready(tri_rdy), .o_culled_count(culled), .o_overrun(overrun)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return v < 0 ? 0 : (v > hi ? hi : v);
  endfunction

  task automatic vtx(input int x, input int y, input int z, input bit inv);
    vp[0] = DW'(x);
    vp[1] = DW'(y);
    vz = ZB'(z);
    vinv = inv;
    vdv = 1'b1;
    @(negedge clk);
    vdv = 1'b0;
    vinv = 1'b0;
  endtask

  task automatic set_tri(input int x0, input int y0, input int x1, input int y1, input int x2, input int y2);
    tx = '{x0, x1, x2};
    ty = '{y0, y1, y2};
    tz = '{100, 200, 300};
    tinv = '{0, 0, 0};
  endtask

  task automatic tri_go(input string tag);
    longint a;
    int ex [3];
    int ey [3];
    int ez [3];
    int mnx, mxx, mny, mxy, n;
    bit cull;
    for (int i = 0; i < 3; i++) vtx(tx[i], ty[i], tz[i], tinv[i]);
    a = longint'(tx[1] - tx[0]) * (ty[2] - ty[0]) - longint'(tx[2] - tx[0]) * (ty[1] - ty[0]);
    mnx = tx[0]; mxx = tx[0]; mny = ty[0]; mxy = ty[0];
    for (int i = 1; i < 3; i++) begin
      mnx = tx[i] < mnx ? tx[i] : mnx;
      mxx = tx[i] > mxx ? tx[i] : mxx;
      mny = ty[i] < mny ? ty[i] : mny;
      mxy = ty[i] > mxy ? ty[i] : mxy;
    end
    cull = tinv[0] || tinv[1] || tinv[2] || a == 0 || mxx < 0 || mnx > 319 || mxy < 0 || mny > 319;
`ifdef BACKFACE_CULL_EN
    cull = cull || a < 0;
`endif
    ex = tx; ey = ty; ez = tz;
    if (a < 0) begin
      ex = '{tx[0], tx[2], tx[1]};
      ey = '{ty[0], ty[2], ty[1]};
      ez = '{tz[0], tz[2], tz[1]};
      a = -a;
    end
    n = 0;
    while (tri_dv !== 1'b1 && int'(culled) == exp_cull && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 3);
    if (cull) begin
      exp_cull++;
      chk({tag, "_culled"}, culled, exp_cull);
      chk({tag, "_nodv"}, tri_dv, 0);
    end else begin
      chk({tag, "_area"}, area, a);
      chk({tag, "_bbminx"}, bminx, clampi(mnx, 319));
      chk({tag, "_bbmaxx"}, bmaxx, clampi(mxx, 319));
      chk({tag, "_bbminy"}, bminy, clampi(mny, 319));
      chk({tag, "_bbmaxy"}, bmaxy, clampi(mxy, 319));
      for (int i = 0; i < 3; i++) begin
        chk({tag, "_x"}, tri_x[i], ex[i]);
        chk({tag, "_y"}, tri_y[i], ey[i]);
        chk({tag, "_z"}, tri_z[i], ez[i]);
      end
      chk({tag, "_culled"}, culled, exp_cull);
      if (tri_rdy) begin
        @(negedge clk);
        chk({tag, "_dvdrop"}, tri_dv, 0);
        chk({tag, "_ready"}, ready, 1);
      end
    end
  endtask

  initial begin
    longint a0;
    int x1;
    vp = '{default: '0};
    repeat (2) @(negedge clk);
    chk("rst_dv", tri_dv, 0);
    chk("rst_area", area, 0);
    chk("rst_culled", culled, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_bbmaxx", bmaxx, 0);
    rstn = 1'b1;
    #1 chk("rst_ready", ready, 1);
    @(negedge clk);
    set_tri(10, 10, 50, 10, 10, 50);
    tri_go("basic");
    set_tri(10, 10, 10, 50, 50, 10);
    tri_go("backface");
    set_tri(10, 10, 50, 10, 10, 50);
    tinv[1] = 1'b1;
    tri_go("invalid");
    set_tri(20, 20, 60, 30, 25, 90);
    tri_go("after_inv");
    set_tri(-20, -20, 400, -20, -20, 400);
    tri_go("clamp");
    set_tri(-50, -60, -10, -60, -50, -5);
    tri_go("offscreen");
    set_tri(5, 5, 10, 10, 15, 15);
    tri_go("degenerate");
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 3; i++) begin
        tx[i] = int'($urandom_range(700)) - 200;
        ty[i] = int'($urandom_range(700)) - 200;
        tz[i] = int'($urandom_range(4095));
        tinv[i] = $urandom_range(15) == 0;
      end
      tri_go("rand");
    end
    chk("pre_overrun", overrun, 0);
    tri_rdy = 1'b0;
    set_tri(30, 40, 200, 60, 90, 250);
    tri_go("stall");
    a0 = area;
    x1 = tri_x[1];
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        vp[0] = 12'sd7;
        vdv = 1'b1;
      end
      @(negedge clk);
      vdv = 1'b0;
      chk("stall_dv", tri_dv, 1);
      chk("stall_ready", ready, 0);
      chk("stall_area", area, a0);
      chk("stall_x1", tri_x[1], x1);
    end
    chk("stall_overrun", overrun, 1);
    tri_rdy = 1'b1;
    @(negedge clk);
    chk("stall_release", tri_dv, 0);
    chk("stall_ready_back", ready, 1);
    vtx(1, 2, 3, 0);
    vtx(100, 2, 3, 0);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_area", area, 0);
    chk("mid_rst_x0", tri_x[0], 0);
    chk("mid_rst_culled", culled, 0);
    chk("mid_rst_overrun", overrun, 0);
    @(negedge clk);
    rstn = 1'b1;
    exp_cull = 0;
    #1 chk("mid_rst_ready", ready, 1);
    @(negedge clk);
    set_tri(40, 40, 120, 50, 60, 140);
    tri_go("post_rst");
    repeat (4) @(negedge clk);
    chk("post_rst_quiet", tri_dv, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
